rv_ctl_hs: RTL and testbench
============================

// Module: rv_ctl_hs
// PURPOSE
//  Multicycle RISC-V control FSM, next generation: memory accesses use a req/ready handshake with
//  wait states and a bounded timeout. Adds BNE, a full I-type ALU class, an illegal-instruction
//  trap and a retired-instruction counter. Drives the existing multicycle datapath; select
//  encodings come from the shared params include.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for mem_ready in any memory state; 0 disables the timeout
//  RETIRE_W     32  width of retire_cnt
//  TO_W         $clog2(MEM_TIMEOUT+1)  width of the wait counter (derived, not overridden)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  instr       in   32  IR contents
//  zero        in   1   ALU zero flag
//  mem_ready   in   1   memory completes the current access this cycle
//  mem_req     out  1   memory access request (fetch, load, store)
//  memrw       out  1   1 = write; valid only with mem_req
//  pcsource    out  1   PC_INC / PC_ALU
//  pcwrite     out  1   PC load enable
//  pccen       out  1   PCC (current-PC copy) load enable
//  irwrite     out  1   IR load enable
//  mdrwrite    out  1   MDR load enable
//  wbsel       out  2   WB_PC / WB_MDR / WB_ALUOUT
//  regwen      out  1   register file write enable
//  immsel      out  2   IMM_L / IMM_S / IMM_B / IMM_J
//  asel        out  2   ALUA_REG / ALUA_PCC / ALUA_OUT
//  bsel        out  2   ALUB_REG / ALUB_IMM / ALUB_FFF
//  alusel      out  4   ALU function code
//  trap        out  1   sticky: FSM halted in TRAP
//  trap_cause  out  2   0 none, 1 illegal opcode, 2 memory timeout
//  retire_cnt  out  RETIRE_W  instructions completed since reset
// BEHAVIOUR
//  Reset: state=FETCH, wait_cnt=0, retire_cnt=0, trap=0, trap_cause=0. All controls default to
//   0 / PC_INC / WB_PC / IMM_B / ALUA_REG / ALUB_REG / ALU_ADD in every state unless set below.
//   rst in any state, including mid-wait or TRAP, takes effect at the next edge.
//  Decode key {instr[6:0],instr[14:12]}; new constants BNE and ALUI join LW SW ALU BEQ JAL.
//  States and transitions:
//   FETCH: mem_req=1. Wait while !mem_ready. On mem_ready: irwrite=pcwrite=pccen=1 -> DECODE.
//   DECODE: asel=PCC, bsel=IMM, immsel=IMM_B, ADD (branch target into ALUOUT). Next state:
//     LW/SW->LSW_ADDR; ALU->R_ALU; ALUI->I_ALU; BEQ/BNE->BR_EXEC; JAL->JAL_EXEC; else TRAP(cause 1).
//   LSW_ADDR: asel=REG, bsel=IMM, immsel=IMM_L (LW) or IMM_S (SW), ADD -> LW_MEM | SW_MEM.
//   LW_MEM: mem_req=1, memrw=0; mdrwrite=mem_ready; on mem_ready -> LW_WB.
//   LW_WB: wbsel=WB_MDR, regwen=1 -> FETCH (retire).
//   SW_MEM: mem_req=1, memrw=1; on mem_ready -> FETCH (retire).
//   R_ALU: REG,REG, alusel={funct3,instr[30]} -> ALU_WB.
//   I_ALU: REG,IMM, immsel=IMM_L, alusel={funct3, (funct3==3'b101)?instr[30]:1'b0} -> ALU_WB.
//   ALU_WB: wbsel=WB_ALUOUT, regwen=1 -> FETCH (retire).
//   BR_EXEC: REG,REG, ALU_SUB, pcsource=PC_ALU; pcwrite = BEQ ? zero : !zero -> FETCH (retire).
//   JAL_EXEC: PCC,IMM, immsel=IMM_J, ADD, pcsource=PC_ALU, pcwrite=1, regwen=1, wbsel=WB_PC
//     -> FETCH (retire).
//   TRAP: all enables 0, mem_req=0; remains until rst.
//  Wait counter: cleared on entry to any memory state and on mem_ready; increments each cycle
//   mem_req=1 && !mem_ready. Stalled cycle with wait_cnt==MEM_TIMEOUT-1 -> TRAP (cause 2).
//   mem_ready on that same cycle wins: the access completes normally.
//  mem_ready outside a memory state is ignored. Controls are held stable while waiting.
//  retire_cnt increments by 1 on the retiring cycle, wraps modulo 2^RETIRE_W, frozen in TRAP.
//  Minimum latency (mem_ready tied high): LW 5, SW 4, R/I-ALU 4, BEQ/BNE 3, JAL 3 cycles.
// STRUCTURE
//  Shared package: state enum, select/ALU encodings, decode keys incl. BNE and ALUI, and
//   trap-cause codes. Sub-module rv_mem_wait_timer: wait counter plus timeout compare.
//   Next-state and output logic remain in two always_comb blocks within this module.
// TESTING
//  mem_ready=1, ADD x3,x1,x2 -> FETCH,DECODE,R_ALU,ALU_WB; regwen in cycle 4; retire_cnt=1.
//  LW with mem_ready low 3 cycles in LW_MEM -> mem_req held 4 cycles; mdrwrite only on 4th.
//  BNE, zero=0 -> pcwrite=1 in BR_EXEC; BEQ, zero=0 -> pcwrite=0; both retire.
//  MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP after 4 stalled cycles, cause=2.
//  instr=32'hFFFFFFFF -> TRAP after DECODE, cause=1; rst one cycle -> FETCH, counters 0.
//  SRAI (funct3=101, instr[30]=1) -> alusel=4'b1011; ADDI -> 4'b0000.

Source files
------------

// File: rtl/rv_ctl_hs_pkg.sv
// Shared encodings for the handshaked multicycle RISC-V controller: states,
// datapath select codes, decode keys and trap causes.
package rv_ctl_hs_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LSW_ADDR, S_LW_MEM, S_LW_WB, S_SW_MEM,
    S_R_ALU, S_I_ALU, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC, S_TRAP
  } state_t;

  localparam logic       PC_INC     = 1'b0;
  localparam logic       PC_ALU     = 1'b1;
  localparam logic [1:0] WB_PC      = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_ALUOUT  = 2'd2;
  localparam logic [1:0] IMM_L      = 2'd0;
  localparam logic [1:0] IMM_S      = 2'd1;
  localparam logic [1:0] IMM_B      = 2'd2;
  localparam logic [1:0] IMM_J      = 2'd3;
  localparam logic [1:0] ALUA_REG   = 2'd0;
  localparam logic [1:0] ALUA_PCC   = 2'd1;
  localparam logic [1:0] ALUA_OUT   = 2'd2;
  localparam logic [1:0] ALUB_REG   = 2'd0;
  localparam logic [1:0] ALUB_IMM   = 2'd1;
  localparam logic [1:0] ALUB_FFF   = 2'd2;
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;

  // Decode key is {opcode, funct3}; classes that ignore funct3 use wildcards
  localparam logic [9:0] K_LW   = 10'b0000011_010;
  localparam logic [9:0] K_SW   = 10'b0100011_010;
  localparam logic [9:0] K_ALU  = 10'b0110011_???;
  localparam logic [9:0] K_ALUI = 10'b0010011_???;
  localparam logic [9:0] K_BEQ  = 10'b1100011_000;
  localparam logic [9:0] K_BNE  = 10'b1100011_001;
  localparam logic [9:0] K_JAL  = 10'b1101111_???;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       memrw;
    logic       pcsource;
    logic       pcwrite;
    logic       pccen;
    logic       irwrite;
    logic       mdrwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [1:0] immsel;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [3:0] alusel;
  } ctl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LW_MEM) || (s == S_SW_MEM);
  endfunction

endpackage

// File: rtl/rv_ctl_hs_if.sv
// Controller <-> datapath/memory bundle; master is the control FSM.
interface rv_ctl_hs_if #(parameter int RETIRE_W = 32);
  logic [31:0]         instr;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                memrw;
  logic                pcsource;
  logic                pcwrite;
  logic                pccen;
  logic                irwrite;
  logic                mdrwrite;
  logic [1:0]          wbsel;
  logic                regwen;
  logic [1:0]          immsel;
  logic [1:0]          asel;
  logic [1:0]          bsel;
  logic [3:0]          alusel;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [RETIRE_W-1:0] retire_cnt;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, memrw, pcsource, pcwrite, pccen, irwrite, mdrwrite,
           wbsel, regwen, immsel, asel, bsel, alusel, trap, trap_cause, retire_cnt
  );
  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, memrw, pcsource, pcwrite, pccen, irwrite, mdrwrite,
           wbsel, regwen, immsel, asel, bsel, alusel, trap, trap_cause, retire_cnt
  );
endinterface

// File: rtl/rv_mem_wait_timer.sv
// Counts stalled memory cycles; flags the stall that would exceed MEM_TIMEOUT.
module rv_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic timeout
);
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int CW   = (TO_W > 0) ? TO_W : 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) wait_cnt <= '0;
    else if (stall)   wait_cnt <= wait_cnt + CW'(1);
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_to
      assign timeout = 1'b0;
    end else begin : g_to
      assign timeout = stall && (wait_cnt == CW'(MEM_TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/rv_ctl_hs.sv
// Multicycle RISC-V control FSM with req/ready memory handshake, timeout and
// illegal-instruction traps, and a retired-instruction counter.
module rv_ctl_hs
  import rv_ctl_hs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input logic          clk,
  input logic          rst,
  rv_ctl_hs_if.master  bus
);
  state_t              state, state_next;
  ctl_t                c;
  logic                retire, timeout, clear, stall;
  logic [1:0]          cause_next, trap_cause;
  logic                trap;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [9:0]          key;
  logic [2:0]          funct3;

  assign key    = {bus.instr[6:0], bus.instr[14:12]};
  assign funct3 = bus.instr[14:12];

  // Restart the wait count on entering a memory state and whenever an access completes
  assign clear = (is_mem_state(state_next) && state_next != state) ||
                 (is_mem_state(state) && bus.mem_ready);
  assign stall = c.mem_req && !bus.mem_ready;

  rv_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clear(clear), .stall(stall), .timeout(timeout)
  );

  always_comb begin
    state_next = state;
    cause_next = TC_NONE;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
                  else if (timeout) begin state_next = S_TRAP; cause_next = TC_TIMEOUT; end
      S_DECODE: begin
        casez (key)
          K_LW, K_SW:   state_next = S_LSW_ADDR;
          K_ALU:        state_next = S_R_ALU;
          K_ALUI:       state_next = S_I_ALU;
          K_BEQ, K_BNE: state_next = S_BR_EXEC;
          K_JAL:        state_next = S_JAL_EXEC;
          default: begin state_next = S_TRAP; cause_next = TC_ILLEGAL; end
        endcase
      end
      S_LSW_ADDR: state_next = (key == K_SW) ? S_SW_MEM : S_LW_MEM;
      S_LW_MEM:   if (bus.mem_ready) state_next = S_LW_WB;
                  else if (timeout) begin state_next = S_TRAP; cause_next = TC_TIMEOUT; end
      S_SW_MEM:   if (bus.mem_ready) state_next = S_FETCH;
                  else if (timeout) begin state_next = S_TRAP; cause_next = TC_TIMEOUT; end
      S_LW_WB, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC: state_next = S_FETCH;
      S_R_ALU, S_I_ALU: state_next = S_ALU_WB;
      default:    state_next = state;
    endcase
  end

  always_comb begin
    c          = '0;
    c.pcsource = PC_INC;
    c.wbsel    = WB_PC;
    c.immsel   = IMM_B;
    c.asel     = ALUA_REG;
    c.bsel     = ALUB_REG;
    c.alusel   = ALU_ADD;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.irwrite = bus.mem_ready;
        c.pcwrite = bus.mem_ready;
        c.pccen   = bus.mem_ready;
      end
      S_DECODE:   begin c.asel = ALUA_PCC; c.bsel = ALUB_IMM; end
      S_LSW_ADDR: begin
        c.bsel   = ALUB_IMM;
        c.immsel = (key == K_SW) ? IMM_S : IMM_L;
      end
      S_LW_MEM:   begin c.mem_req = 1'b1; c.mdrwrite = bus.mem_ready; end
      S_LW_WB:    begin c.wbsel = WB_MDR; c.regwen = 1'b1; retire = 1'b1; end
      S_SW_MEM:   begin c.mem_req = 1'b1; c.memrw = 1'b1; retire = bus.mem_ready; end
      S_R_ALU:    c.alusel = {funct3, bus.instr[30]};
      S_I_ALU: begin
        // instr[30] is an immediate bit except for the shift-right pair
        c.bsel   = ALUB_IMM;
        c.immsel = IMM_L;
        c.alusel = {funct3, (funct3 == 3'b101) ? bus.instr[30] : 1'b0};
      end
      S_ALU_WB:   begin c.wbsel = WB_ALUOUT; c.regwen = 1'b1; retire = 1'b1; end
      S_BR_EXEC: begin
        c.alusel   = ALU_SUB;
        c.pcsource = PC_ALU;
        c.pcwrite  = (key == K_BNE) ? !bus.zero : bus.zero;
        retire     = 1'b1;
      end
      S_JAL_EXEC: begin
        c.asel = ALUA_PCC; c.bsel = ALUB_IMM; c.immsel = IMM_J;
        c.pcsource = PC_ALU; c.pcwrite = 1'b1; c.regwen = 1'b1; c.wbsel = WB_PC;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      retire_cnt <= '0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
    end else begin
      state <= state_next;
      if (retire) retire_cnt <= retire_cnt + RETIRE_W'(1);
      if (state_next == S_TRAP && state != S_TRAP) begin
        trap       <= 1'b1;
        trap_cause <= cause_next;
      end
    end
  end

  assign bus.mem_req    = c.mem_req;
  assign bus.memrw      = c.memrw;
  assign bus.pcsource   = c.pcsource;
  assign bus.pcwrite    = c.pcwrite;
  assign bus.pccen      = c.pccen;
  assign bus.irwrite    = c.irwrite;
  assign bus.mdrwrite   = c.mdrwrite;
  assign bus.wbsel      = c.wbsel;
  assign bus.regwen     = c.regwen;
  assign bus.immsel     = c.immsel;
  assign bus.asel       = c.asel;
  assign bus.bsel       = c.bsel;
  assign bus.alusel     = c.alusel;
  assign bus.trap       = trap;
  assign bus.trap_cause = trap_cause;
  assign bus.retire_cnt = retire_cnt;
endmodule

// File: tb/tb_rv_ctl_hs.sv
// Directed bench: per-cycle expected control words queued per instruction, popped each cycle.
module tb_rv_ctl_hs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_ctl_hs_if #(.RETIRE_W(32)) bus();
  rv_ctl_hs #(.MEM_TIMEOUT(4), .RETIRE_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_JAL} kind_t;
  typedef struct { string tag; logic rdy; logic [19:0] ctl; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;
  logic [19:0] obs;

  assign obs = {bus.mem_req, bus.memrw, bus.pcsource, bus.pcwrite, bus.pccen, bus.irwrite,
                bus.mdrwrite, bus.wbsel, bus.regwen, bus.immsel, bus.asel, bus.bsel, bus.alusel};

  function automatic logic [19:0] cw(input logic req, rw, pcs, pcw, pcc, ir, mdr,
                                     input logic [1:0] wb, input logic rg,
                                     input logic [1:0] imm, a, b, input logic [3:0] alu);
    return {req, rw, pcs, pcw, pcc, ir, mdr, wb, rg, imm, a, b, alu};
  endfunction

  localparam logic [19:0] C_FWAIT = {1'b1, 6'b0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 4'd0};
  localparam logic [19:0] C_FETCH = {1'b1, 2'b00, 3'b111, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 4'd0};
  localparam logic [19:0] C_DEC   = {7'b0, 2'd0, 1'b0, 2'd2, 2'd1, 2'd1, 4'd0};
  localparam logic [19:0] C_TRAP  = {7'b0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 4'd0};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic [19:0] c);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.ctl = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      @(negedge clk);
      bus.mem_ready = e.rdy;
      #1;
      chk(e.tag, {44'b0, obs}, {44'b0, e.ctl});
    end
  endtask

  // Queue the expected per-cycle controls of one instruction, then replay and check retirement
  task automatic run(input string tag, input kind_t k, input logic [31:0] ins, input logic z,
                     input logic [3:0] alu, input logic pcw, input int stall_f, input int stall_m);
    bus.instr = ins;
    bus.zero  = z;
    for (int i = 0; i < stall_f; i++) push({tag, "_fwait"}, 1'b0, C_FWAIT);
    push({tag, "_fetch"}, 1'b1, C_FETCH);
    push({tag, "_decode"}, 1'b1, C_DEC);
    case (k)
      K_R: begin
        push({tag, "_ralu"}, 1'b1, cw(0,0,0,0,0,0,0, 2'd0, 0, 2'd2, 2'd0, 2'd0, alu));
        push({tag, "_wb"},   1'b1, cw(0,0,0,0,0,0,0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 4'd0));
      end
      K_I: begin
        push({tag, "_ialu"}, 1'b1, cw(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 2'd1, alu));
        push({tag, "_wb"},   1'b1, cw(0,0,0,0,0,0,0, 2'd2, 1, 2'd2, 2'd0, 2'd0, 4'd0));
      end
      K_LW: begin
        push({tag, "_addr"}, 1'b1, cw(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 2'd0, 2'd1, 4'd0));
        for (int i = 0; i < stall_m; i++)
          push({tag, "_mwait"}, 1'b0, cw(1,0,0,0,0,0,0, 2'd0, 0, 2'd2, 2'd0, 2'd0, 4'd0));
        push({tag, "_mem"}, 1'b1, cw(1,0,0,0,0,0,1, 2'd0, 0, 2'd2, 2'd0, 2'd0, 4'd0));
        push({tag, "_wb"},  1'b1, cw(0,0,0,0,0,0,0, 2'd1, 1, 2'd2, 2'd0, 2'd0, 4'd0));
      end
      K_SW: begin
        push({tag, "_addr"}, 1'b1, cw(0,0,0,0,0,0,0, 2'd0, 0, 2'd1, 2'd0, 2'd1, 4'd0));
        for (int i = 0; i < stall_m; i++)
          push({tag, "_mwait"}, 1'b0, cw(1,1,0,0,0,0,0, 2'd0, 0, 2'd2, 2'd0, 2'd0, 4'd0));
        push({tag, "_mem"}, 1'b1, cw(1,1,0,0,0,0,0, 2'd0, 0, 2'd2, 2'd0, 2'd0, 4'd0));
      end
      K_BR:
        push({tag, "_br"}, 1'b1, cw(0,0,1,pcw,0,0,0, 2'd0, 0, 2'd2, 2'd0, 2'd0, 4'b0001));
      K_JAL:
        push({tag, "_jal"}, 1'b1, cw(0,0,1,1,0,0,0, 2'd0, 1, 2'd3, 2'd1, 2'd1, 4'd0));
      default: ;
    endcase
    drain();
    exp_ret++;
    @(posedge clk); #1;
    chk({tag, "_retire"}, {32'b0, bus.retire_cnt}, 64'(exp_ret));
  endtask

  task automatic reset_cycle();
    @(negedge clk); rst = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    exp_ret = 0;
    chk("rst_retire", {32'b0, bus.retire_cnt}, 64'd0);
    chk("rst_trap",   {63'b0, bus.trap}, 64'd0);
    chk("rst_cause",  {62'b0, bus.trap_cause}, 64'd0);
    chk("rst_ctl",    {44'b0, obs}, {44'b0, C_FWAIT});
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    reset_cycle();

    run("add",   K_R,   32'h002081B3, 1'b0, 4'b0000, 1'b0, 0, 0);
    run("sub",   K_R,   32'h402081B3, 1'b0, 4'b0001, 1'b0, 0, 0);
    run("lw",    K_LW,  32'h0040A283, 1'b0, 4'b0000, 1'b0, 3, 3);
    run("sw",    K_SW,  32'h0050A423, 1'b0, 4'b0000, 1'b0, 1, 2);
    run("bne_z0", K_BR, 32'h00209463, 1'b0, 4'b0001, 1'b1, 0, 0);
    run("beq_z0", K_BR, 32'h00208463, 1'b0, 4'b0001, 1'b0, 0, 0);
    run("beq_z1", K_BR, 32'h00208463, 1'b1, 4'b0001, 1'b1, 0, 0);
    run("bne_z1", K_BR, 32'h00209463, 1'b1, 4'b0001, 1'b0, 0, 0);
    run("jal",   K_JAL, 32'h010000EF, 1'b0, 4'b0000, 1'b1, 0, 0);
    run("srai",  K_I,   32'h4020D193, 1'b0, 4'b1011, 1'b0, 0, 0);
    run("srli",  K_I,   32'h0020D193, 1'b0, 4'b1010, 1'b0, 0, 0);
    run("addi",  K_I,   32'h00508193, 1'b0, 4'b0000, 1'b0, 0, 0);
    run("addin", K_I,   32'hC0008193, 1'b0, 4'b0000, 1'b0, 0, 0);
    run("xori",  K_I,   32'h4000C193, 1'b0, 4'b1000, 1'b0, 0, 0);

    // Illegal opcode: trap after DECODE, then stays put while mem_ready toggles
    bus.instr = 32'hFFFFFFFF;
    push("ill_fetch", 1'b1, C_FETCH);
    push("ill_decode", 1'b1, C_DEC);
    drain();
    @(posedge clk); #1;
    chk("ill_trap",   {63'b0, bus.trap}, 64'd1);
    chk("ill_cause",  {62'b0, bus.trap_cause}, 64'd1);
    chk("ill_ctl",    {44'b0, obs}, {44'b0, C_TRAP});
    chk("ill_retire", {32'b0, bus.retire_cnt}, 64'(exp_ret));
    repeat (3) @(posedge clk); #1;
    chk("ill_hold",   {44'b0, obs}, {44'b0, C_TRAP});
    chk("ill_hold_retire", {32'b0, bus.retire_cnt}, 64'(exp_ret));

    // Memory timeout: the reset cycle is the first stall, three more follow
    reset_cycle();
    for (int i = 0; i < 3; i++) push("to_fwait", 1'b0, C_FWAIT);
    drain();
    @(posedge clk); #1;
    chk("to_trap",   {63'b0, bus.trap}, 64'd1);
    chk("to_cause",  {62'b0, bus.trap_cause}, 64'd2);
    chk("to_ctl",    {44'b0, obs}, {44'b0, C_TRAP});
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("to_hold",   {44'b0, obs}, {44'b0, C_TRAP});
    chk("to_retire", {32'b0, bus.retire_cnt}, 64'd0);

    // Recovery after reset
    reset_cycle();
    run("add2", K_R, 32'h002081B3, 1'b0, 4'b0000, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
